// File: rtl/fib_seq_gen_if.sv
// Handshake and result bundle for fib_seq_gen.
// Handshake: a request (start with n, seed0, seed1) is taken on a rising clk
// edge where start=1 and ready=1. done_tick pulses for exactly one cycle when
// f/ovf carry the new result. start seen while ready=0 is dropped, not queued.
// state_dbg mirrors the generator's FSM state for observation.
interface fib_seq_gen_if #(
    parameter int W  = 32,
    parameter int IW = 6
);
    logic          start;
    logic [IW-1:0] n;
    logic [W-1:0]  seed0;
    logic [W-1:0]  seed1;
    logic          ready;
    logic          done_tick;
    logic [W-1:0]  f;
    logic          ovf;
    logic [1:0]    state_dbg;

    modport master (
        output start, n, seed0, seed1,
        input  ready, done_tick, f, ovf, state_dbg
    );

    modport slave (
        input  start, n, seed0, seed1,
        output ready, done_tick, f, ovf, state_dbg
    );
endinterface

// File: rtl/fib_seq_gen.sv
// Iterative Fibonacci-type sequence generator with programmable seeds:
// f(0)=seed0, f(1)=seed1, f(k)=f(k-1)+f(k-2), unsigned, W-bit.
// Result f and sticky overflow ovf are registered and held between completions.
// Optional macro FIB_SAT_EN: saturate to 2^W-1 and finish early on the first
// carry-out; without it the arithmetic wraps and ovf only reports the wrap.
module fib_seq_gen #(
    parameter int W  = 32,
    parameter int IW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    fib_seq_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  t0, t1, t0_nxt, t1_nxt;
    logic [IW-1:0] n_reg, n_nxt;
    logic [W-1:0]  f_reg, f_nxt;
    logic          ovf_reg, ovf_nxt;
    logic          ovf_int, ovf_int_nxt;
    logic [W:0]    sum;

    // One extra bit catches the carry out of the W-bit addition.
    assign sum = {1'b0, t1} + {1'b0, t0};

    assign bus.ready     = (state == IDLE);
    assign bus.done_tick = (state == DONE);
    assign bus.f         = f_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.state_dbg = state;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath registers: working terms, index counter, held result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t0      <= '0;
            t1      <= '0;
            n_reg   <= '0;
            f_reg   <= '0;
            ovf_reg <= 1'b0;
            ovf_int <= 1'b0;
        end else begin
            t0      <= t0_nxt;
            t1      <= t1_nxt;
            n_reg   <= n_nxt;
            f_reg   <= f_nxt;
            ovf_reg <= ovf_nxt;
            ovf_int <= ovf_int_nxt;
        end
    end

    // Next-state and datapath update; f/ovf change only when entering DONE.
    always_comb begin
        state_nxt   = state;
        t0_nxt      = t0;
        t1_nxt      = t1;
        n_nxt       = n_reg;
        f_nxt       = f_reg;
        ovf_nxt     = ovf_reg;
        ovf_int_nxt = ovf_int;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    t0_nxt      = bus.seed0;
                    t1_nxt      = bus.seed1;
                    n_nxt       = bus.n;
                    ovf_int_nxt = 1'b0;
                    state_nxt   = OP;
                end
            end
            OP: begin
                if (n_reg == '0) begin
                    f_nxt     = t0;
                    ovf_nxt   = ovf_int;
                    state_nxt = DONE;
                end else if (n_reg == IW'(1)) begin
                    f_nxt     = t1;
                    ovf_nxt   = ovf_int;
                    state_nxt = DONE;
                end else begin
`ifdef FIB_SAT_EN
                    if (sum[W]) begin
                        // First carry-out: clamp and finish immediately.
                        t1_nxt      = '1;
                        f_nxt       = '1;
                        ovf_nxt     = 1'b1;
                        ovf_int_nxt = 1'b1;
                        state_nxt   = DONE;
                    end else begin
                        t1_nxt = sum[W-1:0];
                        t0_nxt = t1;
                        n_nxt  = n_reg - IW'(1);
                    end
`else
                    t1_nxt = sum[W-1:0];
                    t0_nxt = t1;
                    n_nxt  = n_reg - IW'(1);
                    if (sum[W]) ovf_int_nxt = 1'b1;
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen (W=8 so wrap/overflow is easy to reach).
module tb_fib_seq_gen;
    localparam int W  = 8;
    localparam int IW = 6;

    logic clk;
    logic rst_n;

    fib_seq_gen_if #(.W(W), .IW(IW)) bus ();

    fib_seq_gen #(.W(W), .IW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit busy   = 1'b0;

    logic [W:0]   exp_q[$];     // {ovf, f}
    int           done_cyc_q[$];
    logic [W-1:0] last_f   = '0;
    logic         last_ovf = 1'b0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: iterate the recurrence with wide integers.
    task automatic model(input int nn, input logic [W-1:0] s0, input logic [W-1:0] s1,
                         output logic [W-1:0] rf, output logic rovf, output int lat);
        longint a, b, s, lim;
        bit sat;
        lim  = longint'(1) << W;
        a    = longint'(s0);
        b    = longint'(s1);
        rovf = 1'b0;
        sat  = 1'b0;
        lat  = (nn < 2) ? 1 : nn;
        rf   = (nn == 0) ? s0 : s1;
        for (int k = 2; k <= nn && !sat; k++) begin
            s = a + b;
            if (s >= lim) begin
                rovf = 1'b1;
`ifdef FIB_SAT_EN
                sat = 1'b1;
                rf  = '1;
                lat = k - 1;
`endif
                s = s % lim;
            end
            a = b;
            b = s;
            if (!sat) rf = W'(b);
        end
    endtask

    // ---------------- driver ----------------
    task automatic issue(input int nn, input logic [W-1:0] s0, input logic [W-1:0] s1,
                         input bit hold, output int acc_cyc);
        int w;
        logic [W-1:0] ef;
        logic eo;
        int lat;
        w = 0;
        @(negedge clk);
        while (!bus.ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.ready) begin
            errors++;
            $display("FAIL ready_timeout: got ready=0 want ready=1 within 200 cycles");
        end
        bus.start = 1'b1;
        bus.n     = IW'(nn);
        bus.seed0 = s0;
        bus.seed1 = s1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        model(nn, s0, s1, ef, eo, lat);
        exp_q.push_back({eo, ef});
        done_cyc_q.push_back(acc_cyc + lat);
        busy = 1'b1;
        if (!hold) bus.start = 1'b0;
        // Inputs are free to change once accepted.
        bus.n     = IW'($urandom_range(0, 63));
        bus.seed0 = W'($urandom);
        bus.seed1 = W'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results want 0", exp_q.size());
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W:0] e;
        int dc;
        check("ready", 64'(bus.ready), 64'(!busy));
        if (bus.done_tick) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done_tick=1 want 0 (cycle %0d)", cyc);
            end else begin
                e  = exp_q.pop_front();
                dc = done_cyc_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(dc));
                check("f", 64'(bus.f), 64'(e[W-1:0]));
                check("ovf", 64'(bus.ovf), 64'(e[W]));
                last_f   = e[W-1:0];
                last_ovf = e[W];
            end
            busy = 1'b0;
        end else begin
            check("f_hold", 64'(bus.f), 64'(last_f));
            check("ovf_hold", 64'(bus.ovf), 64'(last_ovf));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int a, prev;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.n     = '0;
        bus.seed0 = '0;
        bus.seed1 = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_done", 64'(bus.done_tick), 64'd0);
        check("rst_f", 64'(bus.f), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        #2 rst_n = 1'b1;

        // Plain Fibonacci n=10, then n=0 and n=1.
        issue(10, 8'd0, 8'd1, 1'b0, a);
        issue(0, 8'd0, 8'd1, 1'b0, a);
        issue(1, 8'd0, 8'd1, 1'b0, a);

        // Lucas n=5, with a start pulse during OP that must be ignored.
        issue(5, 8'd2, 8'd1, 1'b0, a);
        @(negedge clk);
        bus.start = 1'b1;
        bus.n     = IW'(3);
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Wrap / saturation case.
        issue(20, 8'd0, 8'd1, 1'b0, a);
        drain();

        // Asynchronous reset in the middle of a long operation.
        issue(30, 8'd0, 8'd1, 1'b0, a);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(bus.ready), 64'd1);
        check("midrst_f", 64'(bus.f), 64'd0);
        check("midrst_ovf", 64'(bus.ovf), 64'd0);
        exp_q.delete();
        done_cyc_q.delete();
        busy     = 1'b0;
        last_f   = '0;
        last_ovf = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(7, 8'd0, 8'd1, 1'b0, a);
        drain();

        // start held high: one completion every 4 cycles.
        issue(2, 8'd0, 8'd1, 1'b1, prev);
        for (int i = 0; i < 3; i++) begin
            bus.n     = IW'(2);
            bus.seed0 = 8'd0;
            bus.seed1 = 8'd1;
            issue(2, 8'd0, 8'd1, 1'b1, a);
            check("held_period", 64'(a - prev), 64'd4);
            prev = a;
        end
        bus.start = 1'b0;
        drain();

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 24), W'($urandom), W'($urandom), 1'b0, a);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
